fifo_burst_reader: RTL



---
 rtl/gact_fifo_pkg.sv | 22 ++
 rtl/gact_skid_buffer2.sv | 60 ++++++
 rtl/fifo_burst_reader.sv | 107 ++++++++++
 3 files changed

// File: rtl/gact_fifo_pkg.sv
// Shared definitions for the GACT count-FIFO read path.
// Holds the controller state encoding and the skid buffer sizing.
// Imported by the burst reader and its skid buffer.
package gact_fifo_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_RUN   = RUN,
    S_DRAIN = DRAIN,
    S_DONE  = DONE
  } state_t;

  // Two entries cover the BRAM read latency plus one held beat.
  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/gact_skid_buffer2.sv
// Purpose: 2-entry registered buffer between the BRAM read port and the stream.
// Latency: an entry pushed in cycle t is visible at the head in cycle t+1.
// Backpressure: none internally; the caller never pushes into a full buffer.
module gact_skid_buffer2
  import gact_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [OCC_WIDTH-1:0]  count;
  logic                  pop_ok;

  // A pop on an empty buffer is meaningless, so it is ignored.
  assign pop_ok     = pop & head_valid;
  assign head_valid = (count != '0);
  assign head_data  = slot0;
  assign occupancy  = count;

  // slot0 is always the head; slot1 only holds data when two entries are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == '0) slot0 <= push_data;
          else             slot1 <= push_data;
          count <= count + OCC_WIDTH'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - OCC_WIDTH'(1);
        end
        2'b11: begin
          if (count == OCC_WIDTH'(1)) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Purpose: pops a commanded burst from the count FIFO and streams it with out_last.
// Latency: start in cycle 0, first pop in cycle 1, first beat in cycle 3, then 1 beat/cycle.
// Backpressure: out_ready low holds the head beat; pops stop once two entries are owed.
module fifo_burst_reader
  import gact_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 3,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   burst_start,
  input  logic [LEN_WIDTH-1:0]   burst_len,
  output logic                   burst_busy,
  output logic                   burst_done,
  input  logic [DEPTH_WIDTH:0]   fifo_count,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  input  logic                   out_ready
);

  state_t                 state;
  state_t                 state_nxt;
  logic [LEN_WIDTH-1:0]   pops_left;
  logic [LEN_WIDTH-1:0]   beats_left;
  logic                   rd_inflight;
  logic [OCC_WIDTH-1:0]   skid_occ;
  logic                   beat;
  logic [OCC_WIDTH:0]     occ_net;

  assign beat = out_valid & out_ready;

  // Entries already owed to the skid buffer after this cycle's dequeue; a pop
  // is only safe when this leaves room for the data arriving next cycle.
  assign occ_net = {1'b0, skid_occ}
                 + {{OCC_WIDTH{1'b0}}, rd_inflight}
                 - {{OCC_WIDTH{1'b0}}, beat};

  assign burst_busy = (state != S_IDLE);
  assign burst_done = (state == S_DONE);
  assign out_last   = out_valid & (beats_left == LEN_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and pop decision.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (burst_start) state_nxt = (burst_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        fifo_rd_en = (pops_left != '0) && (fifo_count != '0)
                   && (occ_net < (OCC_WIDTH + 1)'(SKID_DEPTH));
        if (pops_left == '0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat && (beats_left == LEN_WIDTH'(1))) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst counters: loaded on an accepted command, then count pops and beats down.
  always_ff @(posedge clk) begin
    if (rst) begin
      pops_left  <= '0;
      beats_left <= '0;
    end else if ((state == S_IDLE) && burst_start) begin
      pops_left  <= burst_len;
      beats_left <= burst_len;
    end else begin
      if (fifo_rd_en) pops_left  <= pops_left - LEN_WIDTH'(1);
      if (beat)       beats_left <= beats_left - LEN_WIDTH'(1);
    end
  end

  // Tracks the BRAM read latency: data for a pop arrives the following cycle.
  always_ff @(posedge clk) begin
    if (rst) rd_inflight <= 1'b0;
    else     rd_inflight <= fifo_rd_en;
  end

  gact_skid_buffer2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_inflight),
    .push_data  (fifo_rd_data),
    .pop        (beat),
    .head_valid (out_valid),
    .head_data  (out_data),
    .occupancy  (skid_occ)
  );

endmodule
